// File: rtl/panda_dmem_responder.sv
// Data-port responder: word-wide RAM plus a small MMIO window (TOHOST, 64-bit cycle counter, SCRATCH).
// Latency: reads are combinational in the request cycle; writes commit on the next rising clk_i.
// Backpressure: none, every request is serviced in its own cycle. Optional macro PANDA_DMEM_BOUNDS_CHECK_EN.
module panda_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    output logic        range_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] OFF_TOHOST   = 2'd0;
    localparam logic [1:0] OFF_CYCLE_LO = 2'd1;
    localparam logic [1:0] OFF_CYCLE_HI = 2'd2;
    localparam logic [1:0] OFF_SCRATCH  = 2'd3;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          mmio_sel;
    logic          ram_sel;
    logic          out_of_range;
    logic          ram_wr_en;
    logic [1:0]    mmio_off;
    logic          tohost_wr;
    logic          scratch_wr;
    logic [63:0]   cycle_cnt;
    logic [31:0]   scratch_q;
    logic [31:0]   ram_rdata;

    // Byte-lane merge shared by RAM and the writable MMIO registers.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign mmio_sel = (data_addr_i[31:4] == MMIO_BASE[31:4]);
    assign ram_sel  = !mmio_sel;
    assign word_idx = data_addr_i[AW+1:2];
    assign mmio_off = data_addr_i[3:2];

`ifdef PANDA_DMEM_BOUNDS_CHECK_EN
    // Anything above the physical RAM is an error instead of an alias.
    assign out_of_range = ram_sel && (data_addr_i[31:AW+2] != '0);
    assign range_err_o  = out_of_range && !rst_i;
`else
    assign out_of_range = 1'b0;
    assign range_err_o  = 1'b0;
`endif

    // Byte offset within the word is the LSU's business, not ours.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_addr_i[1:0];

    assign ram_wr_en  = ram_sel && !out_of_range && !rst_i && (data_we_i != 4'b0000);
    assign tohost_wr  = mmio_sel && (mmio_off == OFF_TOHOST)  && (data_we_i != 4'b0000);
    assign scratch_wr = mmio_sel && (mmio_off == OFF_SCRATCH) && (data_we_i != 4'b0000);

    // RAM store: no reset on the array, writes blocked while reset is high.
    always_ff @(posedge clk_i) begin
        if (ram_wr_en) begin
            mem[word_idx] <= lane_merge(mem[word_idx], data_wdata_i, data_we_i);
        end
    end

    // MMIO registers and free-running cycle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt      <= 64'd0;
            tohost_valid_o <= 1'b0;
            tohost_data_o  <= 32'd0;
            scratch_q      <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (tohost_wr) begin
                tohost_data_o  <= lane_merge(tohost_data_o, data_wdata_i, data_we_i);
                tohost_valid_o <= 1'b1;
            end
            if (scratch_wr) begin
                scratch_q <= lane_merge(scratch_q, data_wdata_i, data_we_i);
            end
        end
    end

    assign ram_rdata = mem[word_idx];

    // Combinational read mux; out-of-range RAM reads return zero.
    always_comb begin
        data_rdata_o = 32'd0;
        if (mmio_sel) begin
            case (mmio_off)
                OFF_TOHOST:   data_rdata_o = tohost_data_o;
                OFF_CYCLE_LO: data_rdata_o = cycle_cnt[31:0];
                OFF_CYCLE_HI: data_rdata_o = cycle_cnt[63:32];
                OFF_SCRATCH:  data_rdata_o = scratch_q;
                default:      data_rdata_o = 32'd0;
            endcase
        end else if (!out_of_range) begin
            data_rdata_o = ram_rdata;
        end
    end

endmodule

// File: tb/tb_panda_dmem_responder.sv
module tb_panda_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        th_vld;
    logic [31:0] th_dat;
    logic        rerr;

    int n_checks = 0;
    int n_errors = 0;

    panda_dmem_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_addr_i    (addr),
        .data_wdata_i   (wdata),
        .data_we_i      (we),
        .data_rdata_o   (rdata),
        .tohost_valid_o (th_vld),
        .tohost_data_o  (th_dat),
        .range_err_o    (rerr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One-cycle store, returns 1 time unit after the committing edge.
    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        we    = w;
        wdata = d;
        @(posedge clk);
        #1;
        we = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we   = 4'b0000;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        rst   = 1'b1;
        addr  = 32'h8000_0004;
        wdata = 32'd0;
        we    = 4'b0000;

        // Reset state
        #3;
        chk("rst_tohost_vld", {31'd0, th_vld}, 32'd0);
        chk("rst_tohost_dat", th_dat, 32'd0);
        chk("rst_range_err", {31'd0, rerr}, 32'd0);
        rd("rst_cycle_lo", 32'h8000_0004, 32'd0);
        rd("rst_scratch", 32'h8000_000C, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rd("rst_cycle_hold", 32'h8000_0004, 32'd0);

        // Counter: 100 edges after release
        @(negedge clk);
        rst  = 1'b0;
        addr = 32'h8000_0004;
        #1;
        chk("cyc_after_release", rdata, 32'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("cyc_lo_100", rdata, 32'd100);
        rd("cyc_hi_0", 32'h8000_0008, 32'd0);
        addr  = 32'h8000_0004;
        we    = 4'hF;
        wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        we = 4'b0000;
        #1;
        chk("cyc_lo_ro", rdata, 32'd101);

        // RAM word and byte-lane writes
        wr(32'h0000_0010, 4'hF, 32'h1234_5678);
        rd("ram_word_10", 32'h0000_0010, 32'h1234_5678);
        rd("ram_word_13", 32'h0000_0013, 32'h1234_5678);
        wr(32'h0000_0012, 4'b1100, 32'hABCD_0000);
        rd("ram_lane_hi", 32'h0000_0010, 32'hABCD_5678);
        wr(32'h0000_0010, 4'b0001, 32'h0000_00EF);
        rd("ram_lane_b0", 32'h0000_0010, 32'hABCD_56EF);

        // Read during write
        wr(32'h0000_0020, 4'hF, 32'h0000_0001);
        @(negedge clk);
        addr  = 32'h0000_0020;
        we    = 4'hF;
        wdata = 32'h0000_0002;
        #1;
        chk("rdw_old", rdata, 32'h0000_0001);
        @(posedge clk);
        #1;
        we = 4'b0000;
        #1;
        chk("rdw_new", rdata, 32'h0000_0002);

        // SCRATCH and read-only HI
        wr(32'h8000_000C, 4'hF, 32'hCAFE_F00D);
        rd("scratch_word", 32'h8000_000C, 32'hCAFE_F00D);
        wr(32'h8000_000C, 4'b0100, 32'h0055_0000);
        rd("scratch_lane", 32'h8000_000C, 32'hCA55_F00D);
        wr(32'h8000_0008, 4'hF, 32'hFFFF_FFFF);
        rd("cyc_hi_ro", 32'h8000_0008, 32'd0);

        // TOHOST
        wr(32'h0000_0040, 4'hF, 32'h1111_1111);
        chk("tohost_vld_pre", {31'd0, th_vld}, 32'd0);
        wr(32'h8000_0000, 4'hF, 32'h0000_0001);
        chk("tohost_vld", {31'd0, th_vld}, 32'd1);
        chk("tohost_dat", th_dat, 32'd1);
        wr(32'h8000_0000, 4'b0010, 32'h0000_AB00);
        chk("tohost_lane", th_dat, 32'h0000_AB01);
        rd("tohost_read", 32'h8000_0000, 32'h0000_AB01);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tohost_vld", {31'd0, th_vld}, 32'd0);
        chk("arst_tohost_dat", th_dat, 32'd0);
        rd("arst_scratch", 32'h8000_000C, 32'd0);
        rd("arst_cycle_lo", 32'h8000_0004, 32'd0);
        wr(32'h0000_0040, 4'hF, 32'h2222_2222);
        rd("arst_store_dropped", 32'h0000_0040, 32'h1111_1111);
        @(negedge clk);
        rst  = 1'b0;
        addr = 32'h8000_0004;
        #1;
        chk("rel_cycle_0", rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_cycle_1", rdata, 32'd1);

        // Wrap / bounds
        wr(32'h0000_0000, 4'hF, 32'h0000_0000);
        rd("word0_cleared", 32'h0000_0000, 32'h0000_0000);
        chk("inrange_err", {31'd0, rerr}, 32'd0);
        @(negedge clk);
        addr  = 32'h0000_1000;
        we    = 4'hF;
        wdata = 32'h0000_00A5;
        #1;
`ifdef PANDA_DMEM_BOUNDS_CHECK_EN
        chk("oob_err", {31'd0, rerr}, 32'd1);
`else
        chk("oob_err", {31'd0, rerr}, 32'd0);
`endif
        @(posedge clk);
        #1;
        we = 4'b0000;
`ifdef PANDA_DMEM_BOUNDS_CHECK_EN
        rd("oob_word0", 32'h0000_0000, 32'h0000_0000);
        rd("oob_read", 32'h0000_1000, 32'h0000_0000);
`else
        rd("wrap_word0", 32'h0000_0000, 32'h0000_00A5);
        rd("wrap_read", 32'h0000_1000, 32'h0000_00A5);
`endif
        addr = 32'h8000_0000;
        #1;
        chk("mmio_err", {31'd0, rerr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/panda_dmem_responder.md
Name: panda_dmem_responder

Overview:
- Responder end of the core data port: services the single-cycle datapath's load/store requests.
- Request inputs: address, write data and byte-lane write enables.
- Response output: full aligned word on data_rdata_o, read in the same cycle; byte extraction and sign-extension stay in the core LSU.
- Also hosts a small MMIO window (tohost mailbox, 64-bit cycle counter, scratch register) used by simulation and bring-up.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; must be a power of two.
- MMIO_BASE, 32'h8000_0000, MMIO window base; the window is selected when data_addr_i[31:4] == MMIO_BASE[31:4].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_addr_i  in  32  byte address from the core.
- data_wdata_i  in  32  write data, already lane-aligned by the core.
- data_we_i  in  4  byte-lane write enables; 4'b0000 means read or idle.
- data_rdata_o  out  32  combinational word read of the addressed location.
- tohost_valid_o  out  1  sticky flag; set by any TOHOST write.
- tohost_data_o  out  32  current TOHOST register value.
- range_err_o  out  1  RAM-region access beyond DEPTH_WORDS; only present with the optional feature, otherwise tied 0.

Behaviour:
- Decode
  - MMIO window selected when data_addr_i[31:4] == MMIO_BASE[31:4]; everything else is RAM.
  - Word index = data_addr_i[log2(DEPTH_WORDS)+1:2]; data_addr_i[1:0] are ignored.
  - Upper RAM address bits are truncated, so accesses wrap modulo DEPTH_WORDS (unless the optional feature is enabled).
- RAM reads
  - data_rdata_o = mem[index], purely combinational, no added latency.
  - RAM is not cleared by reset; contents before the first write are undefined.
- RAM writes
  - On a rising edge of clk_i, for each b in 0..3 with data_we_i[b]=1: mem[index][8b+7:8b] <= data_wdata_i[8b+7:8b].
  - Lanes with data_we_i[b]=0 are unchanged.
  - Writes are ignored while rst_i is high.
- Read during write, same address: the cycle of the write returns the old word; the cycle after returns the new word.
- MMIO map (offset = data_addr_i[3:2])
  - 0 TOHOST: R/W. Byte-lane writes as for RAM. Any write with data_we_i != 0 sets tohost_valid_o=1 from the next cycle; it stays set until reset.
  - 1 CYCLE_LO: read-only, counter bits [31:0].
  - 2 CYCLE_HI: read-only, counter bits [63:32]. No snapshot: software must re-read HI/LO/HI to get a coherent value.
  - 3 SCRATCH: R/W with byte lanes, no side effects.
  - Writes to read-only offsets are ignored.
- Cycle counter
  - 64-bit, increments by 1 on every rising edge while rst_i is low.
  - Wraps from 2^64-1 to 0.
  - LO carries into HI in the same edge.
- Reset (asynchronous, rst_i=1)
  - tohost_valid_o=0, tohost_data_o=0, cycle counter=0, SCRATCH=0.
  - data_rdata_o follows decode immediately: MMIO reads return reset values; RAM reads return current contents.
  - Reset asserted mid-store: the write in that edge is dropped.
  - On deassertion, the counter reads 0 and increments from the first rising edge after deassertion.
- Simultaneous events: a TOHOST write that also sets tohost_valid_o updates tohost_data_o and the flag on the same edge.

Optional Feature:
- Macro: PANDA_DMEM_BOUNDS_CHECK_EN.
- Defined:
  - A RAM-region access with data_addr_i >= 4*DEPTH_WORDS drives range_err_o=1 combinationally for that cycle.
  - Writes to such addresses are suppressed; reads return 32'h0.
  - range_err_o=0 for MMIO and in-range accesses, and during reset.
- Not defined: range_err_o is tied 0, addresses wrap modulo DEPTH_WORDS, and no check logic is synthesized.

Test Plan:
- Word write then read: write 0x0000_0010 with data_we_i=4'hF, data 0x1234_5678 → next cycle a read of 0x10 returns 0x1234_5678; a read of 0x13 also returns 0x1234_5678.
- Byte-lane writes: after the above, write 0x12 with data_we_i=4'b1100, data 0xABCD_0000 → 0x10 reads 0xABCD_5678. Then write 0x10 with data_we_i=4'b0001, data 0x0000_00EF → 0x10 reads 0xABCD_56EF.
- Read-during-write: at 0x20 holding 0x1, store 0x2 with the same-cycle read → that cycle returns 0x1, the next cycle returns 0x2.
- TOHOST: store 0x8000_0000 data 0x0000_0001 → tohost_valid_o=1 and tohost_data_o=1 from the next cycle; assert rst_i asynchronously mid-cycle → both clear to 0 immediately.
- Cycle counter: release reset, wait 100 edges → CYCLE_LO reads 100 and CYCLE_HI reads 0; a write to 0x8000_0004 has no effect.
- Wrap/bounds with DEPTH_WORDS=1024: store 0xA5 to address 0x1000.
  - Macro off: the store aliases to word 0, so 0x0 reads 0xA5.
  - PANDA_DMEM_BOUNDS_CHECK_EN on: range_err_o=1 that cycle, word 0 is unchanged, and the read of 0x1000 returns 0.
